// File: rtl/arkanoid_pkg.sv
// arkanoid_pkg: shared state codes, timer reload, BCD digit width and default game sizes
package arkanoid_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_t;
    localparam logic [7:0] TIMER_RELOAD = 8'b10110100;
    localparam int BCD_W = 4;
    localparam int DEF_LIVES = 3;
    localparam int DEF_BRICKS = 40;
    localparam int DEF_LEVELS = 4;
endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: 4-digit cascaded BCD score counter, wraps 9999 to 0000
module bcd_score_counter
    import arkanoid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] score
);
    logic [15:0] score_d, score_q;
    logic        carry;
    logic [BCD_W-1:0] dig;
    // ripple the increment through the digits; a digit at 9 rolls to 0 and carries
    always_comb begin
        score_d = score_q;
        carry = inc;
        dig = '0;
        for (int i = 0; i < 4; i++) begin
            dig = score_q[i*BCD_W +: BCD_W];
            score_d[i*BCD_W +: BCD_W] = carry ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
            carry = carry & (dig == 4'd9);
        end
        if (clr) score_d = '0;
    end
    // score register, cleared by reset
    always_ff @(posedge clk) begin
        score_q <= reset ? 16'h0000 : score_d;
    end
    assign score = score_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: Arkanoid game-flow FSM (lives, score, bricks, levels); GAME_CTRL_LEVELS_EN enables multi-level play
module game_ctrl
    import arkanoid_pkg::*;
#(
    parameter int LIVES  = DEF_LIVES,
    parameter int BRICKS = DEF_BRICKS,
    parameter int LEVELS = DEF_LEVELS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        timer_up,
    input  logic        miss,
    input  logic        brick_hit,
    output logic        timer_start,
    output logic        gra_still,
    output logic [2:0]  game_state,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [7:0]  bricks_left,
    output logic [2:0]  level
);
`ifdef GAME_CTRL_LEVELS_EN
    localparam logic [2:0] LAST_LEVEL = 3'(LEVELS - 1);
`else
    localparam logic [2:0] LAST_LEVEL = 3'(LEVELS * 0);
`endif
    state_t      state_d, state_q;
    logic        btn_q;
    logic [1:0]  lives_d, lives_q;
    logic [7:0]  bricks_d, bricks_q;
    logic [2:0]  level_d, level_q;
    logic        gra_still_q;
    logic        btn_rise;
    logic        score_clr, score_inc;

    assign btn_rise = btn & ~btn_q;

    // next-state and Mealy timer_start; hits win over a miss when they clear the level
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        bricks_d = bricks_q;
        level_d = level_q;
        timer_start = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            ST_IDLE: if (btn_rise) begin
                lives_d = 2'(LIVES);
                bricks_d = 8'(BRICKS);
                level_d = 3'd0;
                score_clr = 1'b1;
                timer_start = 1'b1;
                state_d = ST_SERVE;
            end
            ST_SERVE: state_d = (timer_up && btn_rise) ? ST_PLAY : ST_SERVE;
            ST_PLAY: begin
                score_inc = brick_hit;
                if (brick_hit) bricks_d = bricks_q - 8'd1;
                if (brick_hit && bricks_q == 8'd1) begin
                    timer_start = 1'b1;
                    state_d = ST_CLEAR;
                end else if (miss) begin
                    timer_start = 1'b1;
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? ST_OVER : ST_SERVE;
                end
            end
            ST_CLEAR: if (timer_up) begin
                timer_start = 1'b1;
                if (level_q != LAST_LEVEL) begin
                    level_d = level_q + 3'd1;
                    bricks_d = 8'(BRICKS);
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: state_d = timer_up ? ST_IDLE : ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    // all game registers; reset overrides any transition in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            btn_q <= 1'b0;
            lives_q <= 2'(LIVES);
            bricks_q <= 8'(BRICKS);
            level_q <= 3'd0;
            gra_still_q <= 1'b1;
        end else begin
            state_q <= state_d;
            btn_q <= btn;
            lives_q <= lives_d;
            bricks_q <= bricks_d;
            level_q <= level_d;
            gra_still_q <= (state_d != ST_PLAY);
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .score (score)
    );

    assign gra_still = gra_still_q;
    assign game_state = state_q;
    assign lives = lives_q;
    assign bricks_left = bricks_q;
    assign level = level_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and randomized checks of game_ctrl against a behavioural game model
module tb_game_ctrl;
    localparam int LIVES = 3;
    localparam int BRICKS = 40;
    localparam int LEVELS = 4;
`ifdef GAME_CTRL_LEVELS_EN
    localparam bit LEVELS_EN = 1'b1;
`else
    localparam bit LEVELS_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn = 1'b0;
    logic        timer_up = 1'b0;
    logic        miss = 1'b0;
    logic        brick_hit = 1'b0;
    logic        timer_start;
    logic        gra_still;
    logic [2:0]  game_state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [7:0]  bricks_left;
    logic [2:0]  level;
    int n_chk = 0;
    int n_fail = 0;
    int m_st, m_lives, m_score, m_bricks, m_level;
    bit m_btn;

    game_ctrl #(.LIVES(LIVES), .BRICKS(BRICKS), .LEVELS(LEVELS)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .timer_up    (timer_up),
        .miss        (miss),
        .brick_hit   (brick_hit),
        .timer_start (timer_start),
        .gra_still   (gra_still),
        .game_state  (game_state),
        .lives       (lives),
        .score       (score),
        .bricks_left (bricks_left),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk_outputs();
        chk("game_state", 32'(game_state), 32'(m_st));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("score", 32'(score), 32'(to_bcd(m_score)));
        chk("bricks_left", 32'(bricks_left), 32'(m_bricks));
        chk("level", 32'(level), 32'(m_level));
        chk("gra_still", 32'(gra_still), 32'(m_st != 2));
    endtask

    task automatic step(input bit r, input bit b, input bit tu, input bit m, input bit bh);
        int ns, nl, nsc, nb, nlv;
        bit rise, ts;
        @(negedge clk);
        reset = r;
        btn = b;
        timer_up = tu;
        miss = m;
        brick_hit = bh;
        rise = b && !m_btn;
        ts = 1'b0;
        ns = m_st;
        nl = m_lives;
        nsc = m_score;
        nb = m_bricks;
        nlv = m_level;
        case (m_st)
            0: if (rise) begin
                ts = 1'b1; ns = 1; nl = LIVES; nsc = 0; nb = BRICKS; nlv = 0;
            end
            1: if (tu && rise) ns = 2;
            2: begin
                if (bh) begin
                    nsc = (m_score + 1) % 10000;
                    nb = m_bricks - 1;
                end
                if (bh && m_bricks == 1) begin
                    ts = 1'b1; ns = 3;
                end else if (m) begin
                    ts = 1'b1; nl = m_lives - 1; ns = (m_lives == 1) ? 4 : 1;
                end
            end
            3: if (tu) begin
                ts = 1'b1;
                if (LEVELS_EN && m_level < LEVELS - 1) begin
                    nlv = m_level + 1; nb = BRICKS; ns = 1;
                end else ns = 4;
            end
            default: if (tu) ns = 0;
        endcase
        #1;
        if (!r) chk("timer_start", 32'(timer_start), 32'(ts));
        @(posedge clk);
        #1;
        if (r) begin
            m_st = 0; m_lives = LIVES; m_score = 0; m_bricks = BRICKS; m_level = 0; m_btn = 1'b0;
        end else begin
            m_st = ns; m_lives = nl; m_score = nsc; m_bricks = nb; m_level = nlv; m_btn = b;
        end
        chk_outputs();
    endtask

    task automatic start_and_serve();
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_bricks", 32'(bricks_left), 32'd40);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("serve_hold", 32'(game_state), 32'd1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("play", 32'(game_state), 32'd2);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
        end
        chk("score12", 32'(score), 32'h0012);
        chk("bricks12", 32'(bricks_left), 32'd28);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            if (k < 2) begin
                step(0, 0, 0, 0, 0);
                step(0, 1, 1, 0, 0);
            end
        end
        chk("over", 32'(game_state), 32'd4);
        step(0, 0, 1, 0, 0);
        chk("score_kept", 32'(score), 32'h0012);
        start_and_serve();
        for (int i = 0; i < 39; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("clear_lives", 32'(lives), 32'd3);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 499) == 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        step(1, 0, 0, 0, 0);
        start_and_serve();
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("rst_play_score", 32'(score), 32'h0000);
        chk("rst_play_state", 32'(game_state), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
